fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the RV64I/Zba pipeline; sits directly upstream of the IF/ID register.
- Owns the fetch PC and issues requests to the instruction memory over a valid/ready request plus valid response interface.
- Presents PC_F, Instr_F and Valid_F to the IF/ID register, whose enable is driven by !stall_F.
- Handles hazard-unit stalls and execute-stage redirects (taken branch/jump), including discarding a stale in-flight fetch.

Parameters:
- RESET_PC, 64'h0, fetch PC loaded on reset.
- NOP_INSTR, 32'h00000013, value driven on Instr_F whenever Valid_F=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_F  in  1  hazard unit: IF/ID not accepting this cycle.
- redirect_E  in  1  execute stage: taken branch/jump this cycle.
- PCTarget_E  in  64  redirect target address.
- imem_req_valid  out  1  fetch request valid.
- imem_addr  out  64  request address, bits [1:0] always 0.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response data valid.
- imem_rdata  in  32  response instruction word.
- PC_F  out  64  PC of presented instruction.
- Instr_F  out  32  presented instruction.
- Valid_F  out  1  PC_F/Instr_F hold a live instruction.

Behaviour:
- Reset (rst=1 at a clock edge): fetch PC=RESET_PC; state=IDLE; hold register empty; Valid_F=0; PC_F=0; Instr_F=NOP_INSTR; imem_req_valid=0 in the cycle reset is asserted.
- Memory contract: at most one request outstanding. A request is accepted when imem_req_valid && imem_ready. Its response arrives imem_rsp_valid=1 at least 1 cycle after acceptance. Responses return in order.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its response will be delivered.
  - DROP: request outstanding; its response will be discarded.
- imem_req_valid=1 when state=IDLE, the hold register is empty or being consumed this cycle, and redirect_E=0. imem_addr=fetch PC.
- On acceptance: go to WAIT; req_pc := fetch PC; fetch PC := fetch PC+4 (64-bit wrap, no overflow flag).
- WAIT with imem_rsp_valid: load the hold register with {req_pc, imem_rdata}, set valid, return to IDLE. The same-cycle issue of the next request is allowed from IDLE on the following cycle, giving 1 request per 2 cycles minimum with a 1-cycle memory.
- Outputs: PC_F/Instr_F/Valid_F are driven directly from the hold register, not combinationally from imem_rdata.
- Consumption: the hold register entry is consumed when Valid_F && !stall_F. When consumed and no new entry is loaded, Valid_F goes to 0 and Instr_F goes to NOP_INSTR.
- Stall: while stall_F=1 and Valid_F=1, PC_F/Instr_F/Valid_F are held bit-stable. No new request issues while the hold register is full and not consumed.
- Redirect (highest priority, overrides stall):
  - fetch PC := {PCTarget_E[63:2],2'b00}.
  - Hold register cleared, so Valid_F=0 the next cycle.
  - No request issues in the redirect cycle.
  - From WAIT, go to DROP. From IDLE, stay in IDLE.
  - A response arriving in the redirect cycle is discarded.
- DROP with imem_rsp_valid: discard the response and go to IDLE. A redirect during DROP only updates the fetch PC.
- Redirect and response in the same cycle: the redirect wins; state goes to IDLE and no data is loaded.
- Reset mid-operation: any outstanding response arriving after reset is ignored, because state=IDLE accepts no data.

Decomposition:
- Shared package: NOP_INSTR constant, XLEN=64, ILEN=32, and the fetch_state_t enum {IDLE, WAIT, DROP}.
- One natural sub-module: fetch_pc_gen (fetch PC register, +4 incrementer, redirect mux with alignment).
- The hold register and FSM stay in fetch_stage.

Test Plan:
- Reset, then 1-cycle memory with ready always 1 and stall 0 -> requests at 0x0, 0x4, 0x8; Valid_F pulses with PC_F=0x0, 0x4, 0x8 and the matching Instr_F; no address is skipped or duplicated.
- stall_F=1 for 3 cycles while Valid_F=1 at PC 0x4 -> PC_F/Instr_F held stable; no imem request; after release, the next request is at 0x8.
- redirect_E=1, PCTarget_E=0x100, while in WAIT for 0x8 -> the 0x8 response is dropped and never has Valid_F=1; the next request is at 0x100; PC_F=0x100 is delivered.
- redirect_E with PCTarget_E=0x103 -> imem_addr=0x100.
- imem_ready low for 4 cycles -> imem_req_valid stays 1 with imem_addr stable; Valid_F=0 throughout.
- rst asserted while in WAIT, with the response arriving the next cycle -> Valid_F=0, Instr_F=0x00000013; the first new request is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: reset load, sequential +4 advance and aligned redirect.
module fetch_pc_gen
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    // Target low bits are dropped by the word alignment.
    logic unused_target_lsb;
    assign unused_target_lsb = ^target[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= {RESET_PC[XLEN-1:2], 2'b00};
        end else if (redirect) begin
            pc <= {target[XLEN-1:2], 2'b00};
        end else if (advance) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: one-outstanding imem fetch, single-entry hold register, redirect/drop handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [ILEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_F,
    input  logic            redirect_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PC_F,
    output logic [ILEN-1:0] Instr_F,
    output logic            Valid_F
);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            hold_valid;
    logic [XLEN-1:0] hold_pc;
    logic [ILEN-1:0] hold_instr;
    logic            consume;
    logic            accept;

    assign consume        = hold_valid && !stall_F;
    assign imem_req_valid = !rst && (state == IDLE) && (!hold_valid || consume) && !redirect_E;
    assign imem_addr      = fetch_pc;
    assign accept         = imem_req_valid && imem_ready;

    assign PC_F    = hold_pc;
    assign Instr_F = hold_instr;
    assign Valid_F = hold_valid;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk      (clk),
        .rst      (rst),
        .redirect (redirect_E),
        .target   (PCTarget_E),
        .advance  (accept),
        .pc       (fetch_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_pc     <= '0;
            hold_valid <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else if (redirect_E) begin
            // Flush the hold entry; an in-flight request becomes stale unless it lands now.
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            if (state == WAIT) begin
                state <= imem_rsp_valid ? IDLE : DROP;
            end else if (state == DROP && imem_rsp_valid) begin
                state <= IDLE;
            end
        end else begin
            if (consume) begin
                hold_valid <= 1'b0;
                hold_instr <= NOP_INSTR;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= WAIT;
                        req_pc <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state      <= IDLE;
                        hold_valid <= 1'b1;
                        hold_pc    <= req_pc;
                        hold_instr <= imem_rdata;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-cycle instruction memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        stall_F;
    logic        redirect_E;
    logic [63:0] PCTarget_E;
    logic        imem_req_valid;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic [63:0] PC_F;
    logic [31:0] Instr_F;
    logic        Valid_F;

    int checks = 0;
    int passed = 0;

    logic        mem_pend = 1'b0;
    logic [63:0] mem_addr = '0;
    logic        rsp_hold = 1'b0;

    fetch_stage #(
        .RESET_PC  (64'h0),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_F        (stall_F),
        .redirect_E     (redirect_E),
        .PCTarget_E     (PCTarget_E),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .PC_F           (PC_F),
        .Instr_F        (Instr_F),
        .Valid_F        (Valid_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_mem();
        imem_rsp_valid = mem_pend && !rsp_hold;
        imem_rdata     = instr_of(mem_addr);
    endtask

    // One clock: sample handshakes before the edge, advance memory model after it.
    task automatic tick();
        logic        fire;
        logic        rsp;
        logic [63:0] a;
        #1;
        fire = imem_req_valid && imem_ready;
        rsp  = imem_rsp_valid;
        a    = imem_addr;
        @(posedge clk);
        #1;
        if (rsp) mem_pend = 1'b0;
        if (fire) begin
            mem_pend = 1'b1;
            mem_addr = a;
        end
        drive_mem();
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_F = 1'b0; redirect_E = 1'b0; PCTarget_E = '0;
        imem_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rdata = '0;
        tick();
        #1;
        chk("rst_valid", 64'(Valid_F), 64'd0);
        chk("rst_pc", PC_F, 64'h0);
        chk("rst_instr", 64'(Instr_F), 64'(NOP));
        chk("rst_req", 64'(imem_req_valid), 64'd0);
        rst = 1'b0;
        #1;
        // Streaming with 1-cycle memory
        chk("c0_req", 64'(imem_req_valid), 64'd1);
        chk("c0_addr", imem_addr, 64'h0);
        tick();
        chk("c1_req", 64'(imem_req_valid), 64'd0);
        chk("c1_valid", 64'(Valid_F), 64'd0);
        tick();
        chk("c2_valid", 64'(Valid_F), 64'd1);
        chk("c2_pc", PC_F, 64'h0);
        chk("c2_instr", 64'(Instr_F), 64'(instr_of(64'h0)));
        chk("c2_addr", imem_addr, 64'h4);
        chk("c2_req", 64'(imem_req_valid), 64'd1);
        tick();
        chk("c3_valid", 64'(Valid_F), 64'd0);
        tick();
        // Stall for three cycles at PC 0x4
        stall_F = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 64'(Valid_F), 64'd1);
            chk("stall_pc", PC_F, 64'h4);
            chk("stall_instr", 64'(Instr_F), 64'(instr_of(64'h4)));
            chk("stall_req", 64'(imem_req_valid), 64'd0);
            tick();
        end
        stall_F = 1'b0;
        #1;
        chk("rel_valid", 64'(Valid_F), 64'd1);
        chk("rel_pc", PC_F, 64'h4);
        chk("rel_req", 64'(imem_req_valid), 64'd1);
        chk("rel_addr", imem_addr, 64'h8);
        rsp_hold = 1'b1;
        tick();
        // Redirect while waiting on 0x8
        redirect_E = 1'b1; PCTarget_E = 64'h100;
        #1;
        chk("redir_req", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_E = 1'b0;
        rsp_hold = 1'b0;
        drive_mem();
        #1;
        chk("drop_rsp", 64'(imem_rsp_valid), 64'd1);
        chk("drop_req", 64'(imem_req_valid), 64'd0);
        chk("drop_valid", 64'(Valid_F), 64'd0);
        tick();
        chk("post_drop_valid", 64'(Valid_F), 64'd0);
        chk("post_drop_req", 64'(imem_req_valid), 64'd1);
        chk("post_drop_addr", imem_addr, 64'h100);
        tick();
        chk("w100_valid", 64'(Valid_F), 64'd0);
        tick();
        chk("d100_valid", 64'(Valid_F), 64'd1);
        chk("d100_pc", PC_F, 64'h100);
        chk("d100_instr", 64'(Instr_F), 64'(instr_of(64'h100)));
        // Misaligned redirect target
        redirect_E = 1'b1; PCTarget_E = 64'h103;
        #1;
        chk("redir2_req", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_E = 1'b0;
        #1;
        chk("redir2_valid", 64'(Valid_F), 64'd0);
        chk("redir2_instr", 64'(Instr_F), 64'(NOP));
        chk("redir2_addr", imem_addr, 64'h100);
        // Memory not ready for four cycles
        imem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("nrdy_req", 64'(imem_req_valid), 64'd1);
            chk("nrdy_addr", imem_addr, 64'h100);
            chk("nrdy_valid", 64'(Valid_F), 64'd0);
            tick();
        end
        imem_ready = 1'b1;
        #1;
        chk("rdy_addr", imem_addr, 64'h100);
        tick();
        // Reset while waiting; stale response lands the cycle after
        rsp_hold = 1'b1;
        drive_mem();
        rst = 1'b1;
        #1;
        chk("rstw_req", 64'(imem_req_valid), 64'd0);
        tick();
        rst = 1'b0;
        rsp_hold = 1'b0;
        drive_mem();
        #1;
        chk("rstw_valid", 64'(Valid_F), 64'd0);
        chk("rstw_instr", 64'(Instr_F), 64'(NOP));
        chk("rstw_pc", PC_F, 64'h0);
        chk("rstw_req", 64'(imem_req_valid), 64'd1);
        chk("rstw_addr", imem_addr, 64'h0);
        tick();
        chk("rstw_stale_valid", 64'(Valid_F), 64'd0);
        tick();
        chk("rstw_new_valid", 64'(Valid_F), 64'd1);
        chk("rstw_new_pc", PC_F, 64'h0);
        chk("rstw_new_instr", 64'(Instr_F), 64'(instr_of(64'h0)));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
